// File: rtl/move_fetch_ctrl.sv
// Fetch controller for action_ram: reads the action word addressed by a move
// request, validates it against the latched board and hands one cell index downstream.
module move_fetch_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CELLS  = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [2*CELLS-1:0]   req_board,
    input  logic                 ram_we,
    output logic [ADDR_W-1:0]    read_address,
    input  logic [DATA_W-1:0]    d_out,
    output logic                 move_valid,
    input  logic                 move_ready,
    output logic [3:0]           move_cell,
    output logic [1:0]           move_src
);

    localparam int unsigned CELL_W  = 4;
    localparam int unsigned NCODES  = 16;
    localparam int unsigned BOARD_W = 2 * CELLS;

    localparam logic [1:0] SRC_PRIMARY  = 2'd0;
    localparam logic [1:0] SRC_FALLBACK = 2'd1;
    localparam logic [1:0] SRC_SCAN     = 2'd2;
    localparam logic [1:0] SRC_FULL     = 2'd3;
    localparam logic [CELL_W-1:0] NO_CELL = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [CELL_W-1:0]    cell_d;
    logic [1:0]           src_d;
    logic                 valid_d;
    logic                 ready_d;

    logic [CELL_W-1:0]    primary;
    logic [CELL_W-1:0]    fallback;
    logic [NCODES-1:0]    empty_vec;
    logic                 scan_found;
    logic [CELL_W-1:0]    scan_cell;
    logic                 unused_low_bits;

    assign primary         = d_out[DATA_W-1 -: CELL_W];
    assign fallback        = d_out[DATA_W-CELL_W-1 -: CELL_W];
    assign unused_low_bits = ^d_out[DATA_W-2*CELL_W-1:0];

    // Empty-cell map padded to 16 entries so codes 9..15 always read as not empty.
    always_comb begin
        empty_vec = '0;
        for (int k = 0; k < int'(CELLS); k++) begin
            empty_vec[k] = (board_q[2*k +: 2] == 2'b00);
        end
    end

    // Lowest-index empty cell: iterate downward so the last hit is the lowest.
    always_comb begin
        scan_found = 1'b0;
        scan_cell  = NO_CELL;
        for (int k = int'(CELLS) - 1; k >= 0; k--) begin
            if (empty_vec[k]) begin
                scan_found = 1'b1;
                scan_cell  = CELL_W'(k);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        addr_d  = read_address;
        cell_d  = move_cell;
        src_d   = move_src;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    board_d = req_board;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The RAM holds d_out during loader writes, so wait them out.
                if (!ram_we) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (empty_vec[primary]) begin
                    cell_d = primary;
                    src_d  = SRC_PRIMARY;
                end else if (empty_vec[fallback]) begin
                    cell_d = fallback;
                    src_d  = SRC_FALLBACK;
                end else if (scan_found) begin
                    cell_d = scan_cell;
                    src_d  = SRC_SCAN;
                end else begin
                    cell_d = NO_CELL;
                    src_d  = SRC_FULL;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (move_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            board_q      <= '0;
            read_address <= '0;
            move_cell    <= NO_CELL;
            move_src     <= SRC_PRIMARY;
            move_valid   <= 1'b0;
            req_ready    <= 1'b1;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            read_address <= addr_d;
            move_cell    <= cell_d;
            move_src     <= src_d;
            move_valid   <= valid_d;
            req_ready    <= ready_d;
        end
    end

endmodule
